wb_master: RTL and testbench
============================

WB_MASTER -- requirements
Module: wb_master

Interface
REQ-001 SHALL have parameter AW, default 32, Wishbone address width (>=3).
REQ-002 SHALL have parameter TIMEOUT, default 255, max wait cycles for ACK_I/ERR_I.
REQ-003 SHALL have ports: CLK_I in 1 clock; RST_I in 1 reset; cmd_valid in 1; cmd_ready out 1; cmd_we in 1; cmd_adr in AW byte address; cmd_size in 2 (00 byte, 01 word, 10 long, 11 illegal); cmd_wdata in 32 right-justified; rsp_valid out 1; rsp_ready in 1; rsp_rdata out 32 right-justified; rsp_err out 1; rsp_timeout out 1; ADR_O out AW; DAT_O out 32; DAT_I in 32; SEL_O out 4; WE_O out 1; CYC_O out 1; STB_O out 1; ACK_I in 1; ERR_I in 1.
REQ-004 SHALL use one clock CLK_I; reset RST_I is synchronous and active-low.

Function
REQ-005 SHALL be a Wishbone classic single-transfer initiator; one outstanding command.
REQ-006 SHALL implement states IDLE, BUS, RESP.
REQ-007 cmd_ready SHALL be 1 only in IDLE and not in reset; command accepted on cmd_valid&&cmd_ready.
REQ-008 Byte lanes big-endian: byte offset k (adr[1:0]) -> SEL_O bit 3-k, lane DAT[31-8k:24-8k]; word offset 0 -> 1100, offset 2 -> 0011; long offset 0 -> 1111.
REQ-009 Misaligned (word odd offset, long offset!=0) or size 11: IDLE->RESP, no bus cycle, rsp_err=1, rsp_timeout=0, rsp_rdata=0.
REQ-010 Legal command accepted at edge N: from N+1, CYC_O=STB_O=1, ADR_O={cmd_adr[AW-1:2],2'b00}, WE_O=cmd_we, SEL_O per REQ-008, DAT_O = write data steered to selected lanes, unselected lanes 0 (reads: DAT_O=0); all held stable until termination.
REQ-011 In BUS, ACK_I or ERR_I sampled 1 at edge T terminates: CYC_O/STB_O/SEL_O/WE_O=0 from T, state RESP, rsp_valid=1 from T.
REQ-012 ERR_I SHALL win over simultaneous ACK_I: rsp_err=1.
REQ-013 Read with ACK: rsp_rdata = selected lanes right-justified, zero-extended; write or error: rsp_rdata=0.
REQ-014 Zero-wait responder (combinational ACK) SHALL give rsp_valid at N+2 after acceptance at N.
REQ-015 rsp_valid and response fields held until rsp_valid&&rsp_ready; then IDLE, cmd_ready=1 next cycle.
REQ-016 ACK_I/ERR_I outside BUS SHALL be ignored.

Reset
REQ-017 While RST_I=0 at an edge: state IDLE, CYC_O=STB_O=WE_O=0, SEL_O=0, ADR_O=0, DAT_O=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, wait counter 0.
REQ-018 Reset mid-BUS or mid-RESP SHALL abort: CYC_O/STB_O low after that edge, pending response discarded, no late ACK delivered.

Configuration
REQ-019 Macro WB_MASTER_TIMEOUT_EN defined: counter counts BUS cycles without termination; after TIMEOUT such cycles, CYC_O/STB_O drop, RESP with rsp_err=1, rsp_timeout=1.
REQ-020 Macro undefined: no counter, BUS waits indefinitely, rsp_timeout tied 0, TIMEOUT unused.
REQ-021 Termination on the same edge the counter expires SHALL count as normal termination (ACK/ERR wins).

Structure
REQ-022 Shared package wb_pkg SHALL hold size encodings (SZ_BYTE/SZ_WORD/SZ_LONG), state enum, SEL constants.
REQ-023 Sub-module wb_sel_decode SHALL map (cmd_size, adr[1:0]) to SEL and misaligned flag, combinational.

Verification
REQ-024 Write long 0x11223344 to 0x10, zero-wait memory -> SEL_O=1111, DAT_O=0x11223344, rsp_valid 2 cycles after accept, rsp_err=0.
REQ-025 Read byte 0x13 after REQ-024 -> SEL_O=0001, rsp_rdata=0x00000044; read word 0x12 -> SEL_O=0011, rsp_rdata=0x00003344.
REQ-026 Word at 0x11 -> no CYC_O, rsp_err=1 one cycle after accept.
REQ-027 ACK_I and ERR_I both 1 in one cycle -> rsp_err=1, rsp_rdata=0.
REQ-028 With WB_MASTER_TIMEOUT_EN, TIMEOUT=4, no ACK -> CYC_O drops after 4 BUS cycles, rsp_timeout=1, rsp_err=1.
REQ-029 RST_I=0 mid-BUS, then ACK_I=1 -> CYC_O=0, rsp_valid stays 0, cmd_ready=1 after reset release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone classic master: size encodings, FSM states,
// byte-select constants and lane helpers (big-endian lane numbering).
package wb_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_WORD    = 2'b01;
  localparam logic [1:0] SZ_LONG    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  localparam logic [3:0] SEL_NONE    = 4'b0000;
  localparam logic [3:0] SEL_BYTE0   = 4'b1000;
  localparam logic [3:0] SEL_WORD_HI = 4'b1100;
  localparam logic [3:0] SEL_WORD_LO = 4'b0011;
  localparam logic [3:0] SEL_LONG    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RESP
  } state_e;

  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  // Bit position of the lowest selected lane; right-justifies data on reads.
  function automatic logic [4:0] sel_shift(input logic [3:0] sel);
    logic [4:0] sh;
    sh = 5'd0;
    if (sel[0])      sh = 5'd0;
    else if (sel[1]) sh = 5'd8;
    else if (sel[2]) sh = 5'd16;
    else if (sel[3]) sh = 5'd24;
    return sh;
  endfunction

endpackage

// File: rtl/wb_sel_decode.sv
// Combinational map of (size, byte offset) to Wishbone SEL lanes and a misaligned flag.
module wb_sel_decode
  import wb_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] offset,
  output logic [3:0] sel,
  output logic       misaligned
);

  always_comb begin
    sel        = SEL_NONE;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: sel = SEL_BYTE0 >> offset;
      SZ_WORD: begin
        if (offset[0]) misaligned = 1'b1;
        else           sel = offset[1] ? SEL_WORD_LO : SEL_WORD_HI;
      end
      SZ_LONG: begin
        if (offset != 2'b00) misaligned = 1'b1;
        else                 sel = SEL_LONG;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_master.sv
// Wishbone classic single-transfer master with a valid/ready command and response port.
// Define WB_MASTER_TIMEOUT_EN to abort bus cycles that see no ACK_I/ERR_I within TIMEOUT cycles.
module wb_master
  import wb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_adr,
  input  logic [1:0]    cmd_size,
  input  logic [31:0]   cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_timeout,
  output logic [AW-1:0] ADR_O,
  output logic [31:0]   DAT_O,
  input  logic [31:0]   DAT_I,
  output logic [3:0]    SEL_O,
  output logic          WE_O,
  output logic          CYC_O,
  output logic          STB_O,
  input  logic          ACK_I,
  input  logic          ERR_I
);

  if (AW < 3 || TIMEOUT < 1) begin : g_bad_params
    $error("wb_master: AW must be >= 3 and TIMEOUT must be >= 1");
  end

  state_e        state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [3:0]    dec_sel;
  logic          dec_misaligned;
  logic          accept;
  logic [31:0]   rd_lanes;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
`endif

  wb_sel_decode u_sel_decode (
    .size       (cmd_size),
    .offset     (cmd_adr[1:0]),
    .sel        (dec_sel),
    .misaligned (dec_misaligned)
  );

  assign cmd_ready = (state_q == ST_IDLE) && RST_I;
  assign accept    = cmd_valid && cmd_ready;
  assign rd_lanes  = (DAT_I & sel_mask(sel_q)) >> sel_shift(sel_q);

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
`ifdef WB_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (dec_misaligned) begin
            // Illegal commands never reach the bus; answer with an error immediately.
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            err_d       = 1'b1;
            rdata_d     = '0;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_d       = 1'b0;
`endif
          end else begin
            state_d = ST_BUS;
            cyc_d   = 1'b1;
            we_d    = cmd_we;
            sel_d   = dec_sel;
            adr_d   = {cmd_adr[AW-1:2], 2'b00};
            dat_d   = cmd_we ? ((cmd_wdata << sel_shift(dec_sel)) & sel_mask(dec_sel)) : 32'd0;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      ST_BUS: begin
        // ERR_I takes priority over ACK_I, and both beat an expiring timeout.
        if (ACK_I || ERR_I) begin
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          sel_d       = SEL_NONE;
          rsp_valid_d = 1'b1;
          err_d       = ERR_I;
          rdata_d     = (ERR_I || we_q) ? 32'd0 : rd_lanes;
`ifdef WB_MASTER_TIMEOUT_EN
          tmo_d       = 1'b0;
`endif
        end
`ifdef WB_MASTER_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d     = ST_RESP;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          sel_d       = SEL_NONE;
          rsp_valid_d = 1'b1;
          err_d       = 1'b1;
          tmo_d       = 1'b1;
          rdata_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= SEL_NONE;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
`ifdef WB_MASTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign CYC_O     = cyc_q;
  assign STB_O     = cyc_q;
  assign WE_O      = we_q;
  assign SEL_O     = sel_q;
  assign ADR_O     = adr_q;
  assign DAT_O     = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
`ifdef WB_MASTER_TIMEOUT_EN
  assign rsp_timeout = tmo_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_master.sv
// Directed testbench for wb_master against a small zero-wait memory with injectable ACK/ERR.
// Timeout cases follow WB_MASTER_TIMEOUT_EN, instantiated with TIMEOUT = 4.
module tb_wb_master;

  localparam int AW = 16;

  logic          CLK_I = 1'b0;
  logic          RST_I = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_adr = '0;
  logic [1:0]    cmd_size = 2'b00;
  logic [31:0]   cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] ADR_O;
  logic [31:0]   DAT_O;
  logic [31:0]   DAT_I;
  logic [3:0]    SEL_O;
  logic          WE_O;
  logic          CYC_O;
  logic          STB_O;
  logic          ACK_I;
  logic          ERR_I;

  logic          auto_ack  = 1'b1;
  logic          ack_force = 1'b0;
  logic          err_inj   = 1'b0;
  logic [31:0]   mem [0:15];

  int tests = 0;
  int fails = 0;
  int lat;

  wb_master #(.AW(AW), .TIMEOUT(4)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I), .SEL_O(SEL_O),
    .WE_O(WE_O), .CYC_O(CYC_O), .STB_O(STB_O), .ACK_I(ACK_I), .ERR_I(ERR_I)
  );

  always #5 CLK_I = ~CLK_I;

  assign ACK_I = (auto_ack & CYC_O & STB_O) | ack_force;
  assign ERR_I = err_inj;
  assign DAT_I = mem[ADR_O[5:2]];

  // Memory commits selected lanes on the acknowledging edge.
  always @(posedge CLK_I) begin
    if (CYC_O && STB_O && WE_O && ACK_I && !ERR_I) begin
      for (int i = 0; i < 4; i++)
        if (SEL_O[i]) mem[ADR_O[5:2]][8*i +: 8] <= DAT_O[8*i +: 8];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  // Presents one command for a single cycle; returns one cycle after the accepting edge.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] adr,
                               input logic [1:0] size, input logic [31:0] wdata);
    checkOutput("cmd_ready_pre", {31'd0, cmd_ready}, 32'd1);
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_size  = size;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic waitResp(output int cycles);
    cycles = 1;
    while (!rsp_valid && cycles < 64) begin
      tick();
      cycles++;
    end
    checkOutput("rsp_valid", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic finishResp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    checkOutput("cmd_ready_post", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic readCheck(input string tag, input logic [AW-1:0] adr, input logic [1:0] size,
                           input logic [3:0] exp_sel, input logic [31:0] exp_data);
    applyStimulus(1'b0, adr, size, 32'hDEAD_BEEF);
    checkOutput({tag, "_sel"}, {28'd0, SEL_O}, {28'd0, exp_sel});
    checkOutput({tag, "_dat_o"}, DAT_O, 32'd0);
    checkOutput({tag, "_we"}, {31'd0, WE_O}, 32'd0);
    waitResp(lat);
    checkOutput({tag, "_lat"}, lat, 32'd2);
    checkOutput({tag, "_rdata"}, rsp_rdata, exp_data);
    checkOutput({tag, "_err"}, {31'd0, rsp_err}, 32'd0);
    finishResp();
  endtask

  task automatic writeCheck(input string tag, input logic [AW-1:0] adr, input logic [1:0] size,
                            input logic [31:0] wdata, input logic [3:0] exp_sel,
                            input logic [31:0] exp_dat);
    applyStimulus(1'b1, adr, size, wdata);
    checkOutput({tag, "_cyc"}, {31'd0, CYC_O}, 32'd1);
    checkOutput({tag, "_sel"}, {28'd0, SEL_O}, {28'd0, exp_sel});
    checkOutput({tag, "_dat_o"}, DAT_O, exp_dat);
    checkOutput({tag, "_we"}, {31'd0, WE_O}, 32'd1);
    waitResp(lat);
    checkOutput({tag, "_lat"}, lat, 32'd2);
    checkOutput({tag, "_err"}, {31'd0, rsp_err}, 32'd0);
    checkOutput({tag, "_rdata"}, rsp_rdata, 32'd0);
    finishResp();
  endtask

  task automatic illegalCheck(input string tag, input logic [AW-1:0] adr, input logic [1:0] size);
    applyStimulus(1'b0, adr, size, 32'd0);
    checkOutput({tag, "_no_cyc"}, {31'd0, CYC_O}, 32'd0);
    waitResp(lat);
    checkOutput({tag, "_lat"}, lat, 32'd1);
    checkOutput({tag, "_err"}, {31'd0, rsp_err}, 32'd1);
    checkOutput({tag, "_tmo"}, {31'd0, rsp_timeout}, 32'd0);
    checkOutput({tag, "_rdata"}, rsp_rdata, 32'd0);
    finishResp();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got still running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;

    // Reset state
    repeat (3) tick();
    checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    checkOutput("rst_cyc", {31'd0, CYC_O}, 32'd0);
    checkOutput("rst_stb", {31'd0, STB_O}, 32'd0);
    checkOutput("rst_sel", {28'd0, SEL_O}, 32'd0);
    checkOutput("rst_adr", {16'd0, ADR_O}, 32'd0);
    checkOutput("rst_dat", DAT_O, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    RST_I = 1'b1;
    tick();

    // Long write, then hold the response for a cycle before consuming it
    applyStimulus(1'b1, 16'h0010, 2'b10, 32'h1122_3344);
    checkOutput("wl_cyc", {31'd0, CYC_O}, 32'd1);
    checkOutput("wl_stb", {31'd0, STB_O}, 32'd1);
    checkOutput("wl_sel", {28'd0, SEL_O}, 32'hF);
    checkOutput("wl_adr", {16'd0, ADR_O}, 32'h10);
    checkOutput("wl_dat_o", DAT_O, 32'h1122_3344);
    checkOutput("wl_we", {31'd0, WE_O}, 32'd1);
    waitResp(lat);
    checkOutput("wl_lat", lat, 32'd2);
    checkOutput("wl_err", {31'd0, rsp_err}, 32'd0);
    checkOutput("wl_cyc_drop", {31'd0, CYC_O}, 32'd0);
    tick();
    checkOutput("wl_rsp_hold", {31'd0, rsp_valid}, 32'd1);
    checkOutput("wl_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    finishResp();

    readCheck("rb13", 16'h0013, 2'b00, 4'b0001, 32'h0000_0044);
    readCheck("rw12", 16'h0012, 2'b01, 4'b0011, 32'h0000_3344);
    readCheck("rb10", 16'h0010, 2'b00, 4'b1000, 32'h0000_0011);
    readCheck("rw10", 16'h0010, 2'b01, 4'b1100, 32'h0000_1122);

    // Unselected lanes of write data must be zeroed
    writeCheck("wb15", 16'h0015, 2'b00, 32'h1234_56AB, 4'b0100, 32'h00AB_0000);
    writeCheck("ww16", 16'h0016, 2'b01, 32'hFFFF_BEEF, 4'b0011, 32'h0000_BEEF);
    readCheck("rl14", 16'h0014, 2'b10, 4'b1111, 32'h00AB_BEEF);

    illegalCheck("mis_w11", 16'h0011, 2'b01);
    illegalCheck("mis_l12", 16'h0012, 2'b10);
    illegalCheck("sz11", 16'h0010, 2'b11);

    // ACK and ERR together: error wins
    auto_ack = 1'b0;
    applyStimulus(1'b0, 16'h0010, 2'b10, 32'd0);
    checkOutput("ae_cyc", {31'd0, CYC_O}, 32'd1);
    ack_force = 1'b1;
    err_inj   = 1'b1;
    tick();
    ack_force = 1'b0;
    err_inj   = 1'b0;
    checkOutput("ae_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("ae_err", {31'd0, rsp_err}, 32'd1);
    checkOutput("ae_rdata", rsp_rdata, 32'd0);
    checkOutput("ae_cyc_drop", {31'd0, CYC_O}, 32'd0);
    finishResp();

    // Stray ACK/ERR while idle are ignored
    ack_force = 1'b1;
    err_inj   = 1'b1;
    repeat (2) tick();
    ack_force = 1'b0;
    err_inj   = 1'b0;
    checkOutput("idle_ack_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("idle_ack_ready", {31'd0, cmd_ready}, 32'd1);

    // Wait states: bus held until a late ACK
    applyStimulus(1'b0, 16'h0010, 2'b10, 32'd0);
    repeat (3) tick();
    checkOutput("ws_cyc_held", {31'd0, CYC_O}, 32'd1);
    checkOutput("ws_sel_held", {28'd0, SEL_O}, 32'hF);
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    checkOutput("ws_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("ws_rdata", rsp_rdata, 32'h1122_3344);
    finishResp();

`ifdef WB_MASTER_TIMEOUT_EN
    // No responder: abort after exactly 4 bus cycles
    applyStimulus(1'b0, 16'h0010, 2'b10, 32'd0);
    repeat (3) tick();
    checkOutput("to_cyc_c4", {31'd0, CYC_O}, 32'd1);
    tick();
    checkOutput("to_cyc_drop", {31'd0, CYC_O}, 32'd0);
    checkOutput("to_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("to_tmo", {31'd0, rsp_timeout}, 32'd1);
    checkOutput("to_err", {31'd0, rsp_err}, 32'd1);
    finishResp();
    // ACK on the expiring cycle counts as a normal termination
    applyStimulus(1'b0, 16'h0010, 2'b10, 32'd0);
    repeat (3) tick();
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    checkOutput("tol_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("tol_tmo", {31'd0, rsp_timeout}, 32'd0);
    checkOutput("tol_err", {31'd0, rsp_err}, 32'd0);
    checkOutput("tol_rdata", rsp_rdata, 32'h1122_3344);
    finishResp();
`else
    // Without the timeout feature the bus waits indefinitely
    applyStimulus(1'b0, 16'h0010, 2'b10, 32'd0);
    repeat (20) tick();
    checkOutput("nt_cyc_held", {31'd0, CYC_O}, 32'd1);
    checkOutput("nt_no_rsp", {31'd0, rsp_valid}, 32'd0);
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    checkOutput("nt_tmo", {31'd0, rsp_timeout}, 32'd0);
    checkOutput("nt_rdata", rsp_rdata, 32'h1122_3344);
    finishResp();
`endif

    // Reset mid-BUS, late ACK must not produce a response
    applyStimulus(1'b0, 16'h0010, 2'b10, 32'd0);
    checkOutput("rb_cyc", {31'd0, CYC_O}, 32'd1);
    RST_I = 1'b0;
    tick();
    checkOutput("rb_cyc_drop", {31'd0, CYC_O}, 32'd0);
    checkOutput("rb_stb_drop", {31'd0, STB_O}, 32'd0);
    checkOutput("rb_cmd_ready_rst", {31'd0, cmd_ready}, 32'd0);
    RST_I     = 1'b1;
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    checkOutput("rb_no_rsp", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rb_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    checkOutput("rb_no_rsp_late", {31'd0, rsp_valid}, 32'd0);

    // Reset mid-RESP discards the pending response
    auto_ack = 1'b1;
    applyStimulus(1'b0, 16'h0013, 2'b00, 32'd0);
    waitResp(lat);
    RST_I = 1'b0;
    tick();
    checkOutput("rr_rsp_drop", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rr_rdata_clr", rsp_rdata, 32'd0);
    RST_I = 1'b1;
    tick();
    checkOutput("rr_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
